// File: rtl/prim_sync_pkg.sv
// prim_sync_pkg: shared synchronizer depth limits and the popcount helper for the Gray check.
package prim_sync_pkg;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/prim_flop_2sync_if.sv
// prim_flop_2sync_if: source bus in, synchronized bus and Gray-violation flag out.
interface prim_flop_2sync_if #(
  parameter int Width = 16
);
  logic [Width-1:0] d_i;
  logic [Width-1:0] q_o;
  logic             err_o;
  modport master (output d_i, input q_o, input err_o);
  modport slave  (input d_i, output q_o, output err_o);
endinterface

// File: rtl/prim_flop_sync_stage.sv
// prim_flop_sync_stage: one Width-bit async-reset synchronizer register.
module prim_flop_sync_stage #(
  parameter int               Width      = 16,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_wr_i,
  input  logic             rst_wr_ni,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);
  (* ASYNC_REG = "TRUE", keep = "true" *) logic [Width-1:0] q_r;
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni)
    if (!rst_wr_ni) q_r <= ResetValue;
    else            q_r <= d;
  assign q = q_r;
endmodule

// File: rtl/prim_flop_2sync.sv
// prim_flop_2sync: NumStages-deep flop synchronizer; optional Gray check under PRIM_FLOP_2SYNC_GRAY_CHECK_EN.
module prim_flop_2sync
  import prim_sync_pkg::*;
#(
  parameter int               Width      = 16,
  parameter int               NumStages  = 2,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                clk_wr_i,
  input  logic                rst_wr_ni,
  prim_flop_2sync_if.slave    bus
);
  if (NumStages < MIN_SYNC_STAGES || NumStages > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("prim_flop_2sync: NumStages must be 2..4");
  end
  if (Width < 1 || Width > 64) begin : g_bad_width
    $error("prim_flop_2sync: Width must be 1..64");
  end
  logic [Width-1:0] stg [NumStages+1];
  assign stg[0] = bus.d_i;
  for (genvar i = 0; i < NumStages; i++) begin : g_stage
    prim_flop_sync_stage #(.Width(Width), .ResetValue(ResetValue)) u_stage (
      .clk_wr_i (clk_wr_i),
      .rst_wr_ni(rst_wr_ni),
      .d        (stg[i]),
      .q        (stg[i+1])
    );
  end
  assign bus.q_o = stg[NumStages];
`ifdef PRIM_FLOP_2SYNC_GRAY_CHECK_EN
  logic [Width-1:0] h;
  logic             err;
  // h trails q_o by one cycle, so err fires the cycle after a multi-bit jump on q_o
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni)
    if (!rst_wr_ni) begin
      h   <= ResetValue;
      err <= 1'b0;
    end else begin
      h   <= stg[NumStages];
      err <= popcount(64'(stg[NumStages] ^ h)) > 1;
    end
  assign bus.err_o = err;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_prim_flop_2sync.sv
// tb_prim_flop_2sync: directed vectors on a 2-stage/RV=0 and a 3-stage/RV=8000 instance, scoreboard-checked.
module tb_prim_flop_2sync;
`ifdef PRIM_FLOP_2SYNC_GRAY_CHECK_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif
  localparam int N = 29;
  typedef struct {int k; bit b; logic [15:0] q; logic e;} exp_t;
  exp_t sb[$];
  int n_run = 0, n_fail = 0;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  prim_flop_2sync_if #(.Width(16)) bus_a ();
  prim_flop_2sync_if #(.Width(16)) bus_b ();
  prim_flop_2sync #(.Width(16), .NumStages(2), .ResetValue(16'h0000)) dut_a (
    .clk_wr_i(clk), .rst_wr_ni(rst_n), .bus(bus_a));
  prim_flop_2sync #(.Width(16), .NumStages(3), .ResetValue(16'h8000)) dut_b (
    .clk_wr_i(clk), .rst_wr_ni(rst_n), .bus(bus_b));
  // row k is driven just after rising edge k and checked at the falling edge of the same cycle
  bit          rst_v [N] = '{0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1,1};
  logic [15:0] da_v  [N] = '{16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'h0000,16'h0000,16'h0001,16'h0001,
                             16'h0000,16'h0001,16'h0003,16'h0002,16'h0006,16'h0007,16'h0005,16'h0004,
                             16'h0000,16'h0003,16'h0003,16'h0003,16'h0003,16'h0003,16'hA5A5,16'h5A5A,
                             16'h5A5A,16'h5A5A,16'h5A5A,16'h5A5A,16'h5A5A};
  logic [15:0] db_v  [N] = '{16'h8001,16'h8001,16'h8001,16'h8001,16'h0000,16'h0000,16'h0001,16'h0001,
                             16'h0000,16'h0001,16'h0003,16'h0002,16'h0006,16'h0007,16'h0005,16'h0004,
                             16'h0000,16'h0003,16'h0003,16'h0003,16'h0003,16'h0003,16'hA5A5,16'h5A5A,
                             16'h5A5A,16'h5A5A,16'h5A5A,16'h5A5A,16'h5A5A};
  logic [15:0] qa_v  [N] = '{16'h0000,16'h0000,16'h0000,16'h0000,16'hFFFF,16'hFFFF,16'h0000,16'h0000,
                             16'h0001,16'h0001,16'h0000,16'h0001,16'h0003,16'h0002,16'h0006,16'h0007,
                             16'h0005,16'h0004,16'h0000,16'h0003,16'h0003,16'h0003,16'h0003,16'h0000,
                             16'h0000,16'h0000,16'h5A5A,16'h5A5A,16'h5A5A};
  logic [15:0] qb_v  [N] = '{16'h8000,16'h8000,16'h8000,16'h8000,16'h8000,16'h8001,16'h8001,16'h0000,
                             16'h0000,16'h0001,16'h0001,16'h0000,16'h0001,16'h0003,16'h0002,16'h0006,
                             16'h0007,16'h0005,16'h0004,16'h0000,16'h0003,16'h0003,16'h0003,16'h8000,
                             16'h8000,16'h8000,16'h8000,16'h5A5A,16'h5A5A};
  bit          ea_v  [N] = '{0,0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,1,0};
  bit          eb_v  [N] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,1};
  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, k, act, exp);
    end
  endtask
  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      if (x.b) begin
        chk("q_b", x.k, bus_b.q_o, x.q);
        chk("err_b", x.k, 16'(bus_b.err_o), 16'(x.e));
      end else begin
        chk("q_a", x.k, bus_a.q_o, x.q);
        chk("err_a", x.k, 16'(bus_a.err_o), 16'(x.e));
      end
    end
  initial begin
    bus_a.d_i = 16'hFFFF;
    bus_b.d_i = 16'h8001;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      rst_n     = rst_v[k];
      bus_a.d_i = da_v[k];
      bus_b.d_i = db_v[k];
      sb.push_back('{k: k, b: 1'b0, q: qa_v[k], e: ea_v[k] & GC});
      sb.push_back('{k: k, b: 1'b1, q: qb_v[k], e: eb_v[k] & GC});
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", N, 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
